// File: rtl/key_event_scheduler.sv
// key_event_scheduler: decodes PS/2 keycode words into per-player key levels,
// queues make/break events for the game, and issues a game reset pulse on a long Enter hold.
module key_event_scheduler #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned HOLD_CYCLES = 65_000_000,
    parameter int unsigned RST_PULSE   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] keycode,
    output logic [3:0]  tom_keys,
    output logic [3:0]  jerry_keys,
    output logic        ev_valid,
    output logic [3:0]  ev_data,
    input  logic        ev_ready,
    output logic        ev_overflow,
    output logic        game_rst
);

    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned TMR_MAX = (HOLD_CYCLES > RST_PULSE) ? HOLD_CYCLES : RST_PULSE;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX) + 1;

    typedef enum logic [1:0] {IDLE, HOLD, PULSE, WAIT_REL} ent_state_t;

    logic [15:0]      kc_q;
    logic [7:0]       levels;
    logic [3:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic [3:0]       head_nxt;

    logic             scan_new, is_brk, hit, push, pop, full, do_push;
    logic [2:0]       key_sel;
    logic [3:0]       push_data;
    logic             ent_make, ent_brk;

    ent_state_t       state, state_nxt;
    logic [TMR_W-1:0] tmr, tmr_nxt;
    logic             brk_seen, brk_seen_nxt;

    assign tom_keys   = levels[3:0];
    assign jerry_keys = levels[7:4];

    // Scan decode: new-scan detect, key mapping and event generation
    always_comb begin
        scan_new = (keycode != kc_q);
        is_brk   = (keycode[15:8] == 8'hF0);
        hit      = 1'b1;
        key_sel  = 3'd0;
        case (keycode[7:0])
            8'h1D:   key_sel = 3'd0;
            8'h1C:   key_sel = 3'd1;
            8'h1B:   key_sel = 3'd2;
            8'h23:   key_sel = 3'd3;
            8'h75:   key_sel = 3'd4;
            8'h6B:   key_sel = 3'd5;
            8'h72:   key_sel = 3'd6;
            8'h74:   key_sel = 3'd7;
            default: hit = 1'b0;
        endcase
        // A make flips a released key, a break flips a pressed one
        push      = scan_new && hit && (is_brk == levels[key_sel]);
        push_data = {~is_brk, key_sel};
        ent_make  = scan_new && (keycode[7:0] == 8'h5A) && !is_brk;
        ent_brk   = scan_new && (keycode[7:0] == 8'h5A) && is_brk;
    end

    // FIFO next-state: a push on a full FIFO is accepted when a pop frees a slot
    always_comb begin
        pop       = ev_valid && ev_ready;
        full      = (count == CNT_W'(FIFO_DEPTH));
        do_push   = push && (!full || pop);
        rd_nxt    = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
        count_nxt = count + CNT_W'(do_push) - CNT_W'(pop);
        head_nxt  = (do_push && (wr_ptr == rd_nxt)) ? push_data : mem[rd_nxt];
    end

    // Scan history and key levels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kc_q   <= 16'h0000;
            levels <= 8'h00;
        end else begin
            kc_q <= keycode;
            if (push) levels[key_sel] <= ~levels[key_sel];
        end
    end

    // Event FIFO storage, pointers and registered head/valid/overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= 4'h0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            ev_valid    <= 1'b0;
            ev_data     <= 4'h0;
            ev_overflow <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            rd_ptr   <= rd_nxt;
            count    <= count_nxt;
            ev_valid <= (count_nxt != '0);
            ev_data  <= head_nxt;
            if (push && full && !pop) ev_overflow <= 1'b1;
        end
    end

    // Enter FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tmr      <= '0;
            brk_seen <= 1'b0;
            game_rst <= 1'b0;
        end else begin
            state    <= state_nxt;
            tmr      <= tmr_nxt;
            brk_seen <= brk_seen_nxt;
            game_rst <= (state_nxt == PULSE);
        end
    end

    // Enter FSM next-state: hold timer, fixed-width pulse, re-arm only after release
    always_comb begin
        state_nxt    = state;
        tmr_nxt      = tmr;
        brk_seen_nxt = brk_seen;
        case (state)
            IDLE: begin
                if (ent_make) begin
                    state_nxt = HOLD;
                    tmr_nxt   = '0;
                end
            end
            HOLD: begin
                tmr_nxt = tmr + TMR_W'(1);
                if (ent_brk) begin
                    state_nxt = IDLE;
                end else if (tmr == TMR_W'(HOLD_CYCLES - 1)) begin
                    state_nxt    = PULSE;
                    tmr_nxt      = '0;
                    brk_seen_nxt = 1'b0;
                end
            end
            PULSE: begin
                tmr_nxt = tmr + TMR_W'(1);
                if (ent_brk) brk_seen_nxt = 1'b1;
                if (tmr == TMR_W'(RST_PULSE - 1)) begin
                    state_nxt = (brk_seen || ent_brk) ? IDLE : WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (ent_brk) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_key_event_scheduler.sv
// tb_key_event_scheduler: directed and randomized checks against a queue-based reference model.
module tb_key_event_scheduler;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned HOLD  = 8;
    localparam int unsigned PULSE = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] keycode = 16'h0000;
    logic        ev_ready = 1'b0;
    logic [3:0]  tom_keys, jerry_keys, ev_data;
    logic        ev_valid, ev_overflow, game_rst;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit   [7:0]  m_lvl;
    logic [3:0]  m_q[$];
    bit          m_ovf;
    logic [15:0] m_prev;
    int          m_since;
    int          m_pulse;
    bit          m_brk_in_pulse;
    bit          m_need_rel;
    logic [3:0]  got[$];

    always #5 clk = ~clk;

    key_event_scheduler #(
        .FIFO_DEPTH (DEPTH),
        .HOLD_CYCLES(HOLD),
        .RST_PULSE  (PULSE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .keycode    (keycode),
        .tom_keys   (tom_keys),
        .jerry_keys (jerry_keys),
        .ev_valid   (ev_valid),
        .ev_data    (ev_data),
        .ev_ready   (ev_ready),
        .ev_overflow(ev_overflow),
        .game_rst   (game_rst)
    );

    function automatic int key_slot(input logic [7:0] sc);
        case (sc)
            8'h1D: return 0;
            8'h1C: return 1;
            8'h1B: return 2;
            8'h23: return 3;
            8'h75: return 4;
            8'h6B: return 5;
            8'h72: return 6;
            8'h74: return 7;
            default: return -1;
        endcase
    endfunction

    task automatic m_reset();
        m_lvl = '0;
        m_q.delete();
        m_ovf = 1'b0;
        m_prev = 16'h0000;
        m_since = -1;
        m_pulse = 0;
        m_brk_in_pulse = 1'b0;
        m_need_rel = 1'b0;
    endtask

    // One clock edge of the behavioural model
    task automatic model_edge(input logic [15:0] kc, input bit rdy);
        bit         is_new = (kc !== m_prev);
        bit         brk = (kc[15:8] == 8'hF0);
        int         s = key_slot(kc[7:0]);
        bit         do_pop = (m_q.size() > 0) && rdy;
        bit         push_ev = 1'b0;
        logic [3:0] ev = 4'h0;
        bit         ent = is_new && (kc[7:0] == 8'h5A);
        if (is_new && s >= 0 && (brk == m_lvl[s])) begin
            ev = {~brk, 3'(s)};
            m_lvl[s] = ~m_lvl[s];
            if (m_q.size() < DEPTH || do_pop) push_ev = 1'b1;
            else m_ovf = 1'b1;
        end
        if (do_pop) void'(m_q.pop_front());
        if (push_ev) m_q.push_back(ev);
        if (m_pulse > 0) begin
            if (ent && brk) m_brk_in_pulse = 1'b1;
            m_pulse--;
            if (m_pulse == 0) m_need_rel = !m_brk_in_pulse;
        end else if (m_since >= 0) begin
            if (ent && brk) m_since = -1;
            else begin
                m_since++;
                if (m_since == int'(HOLD)) begin
                    m_since = -1;
                    m_pulse = PULSE;
                    m_brk_in_pulse = 1'b0;
                end
            end
        end else if (m_need_rel) begin
            if (ent && brk) m_need_rel = 1'b0;
        end else if (ent && !brk) begin
            m_since = 0;
        end
        m_prev = kc;
    endtask

    function automatic logic [14:0] exp_vec();
        return {m_lvl[3:0], m_lvl[7:4], m_q.size() > 0,
                (m_q.size() > 0) ? m_q[0] : 4'h0, m_ovf, m_pulse > 0};
    endfunction

    function automatic logic [14:0] obs_vec();
        return {tom_keys, jerry_keys, ev_valid, ev_valid ? ev_data : 4'h0, ev_overflow, game_rst};
    endfunction

    // Drive inputs at the falling edge, advance one cycle, sample at the next falling edge
    task automatic step(input logic [15:0] kc, input bit rdy);
        keycode = kc;
        ev_ready = rdy;
        if (ev_valid && rdy) got.push_back(ev_data);
        @(posedge clk);
        model_edge(kc, rdy);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        keycode = 16'h0000;
        ev_ready = 1'b0;
        m_reset();
        got.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        keycode = 16'h0000;
        ev_ready = 1'b0;
        m_reset();
        @(negedge clk);
        checks++;
        if (obs_vec() !== 15'h0) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=%h", obs_vec(), 15'h0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        got.delete();
    endtask

    task automatic test_tom_make_break();
        logic [15:0] seq [4] = '{16'h001D, 16'h001D, 16'hF01D, 16'hF01D};
        do_reset();
        foreach (seq[i]) begin
            step(seq[i], 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL tom_make_break step=%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
        end
        for (int i = 0; i < 3; i++) step(16'hF01D, 1'b1);
        checks++;
        if (got.size() != 2 || got[0] !== 4'b1000 || got[1] !== 4'b0000) begin
            errors++;
            $display("FAIL tom_events got_n=%0d got=%p want=8,0", got.size(), got);
        end
    endtask

    task automatic test_typematic();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(16'h0075, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec() || jerry_keys[0] !== 1'b1) begin
                errors++;
                $display("FAIL typematic step=%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
        end
        step(16'hF075, 1'b0);
        for (int i = 0; i < 4; i++) step(16'hF075, 1'b1);
        checks++;
        if (got.size() != 2 || got[0] !== 4'b1100 || got[1] !== 4'b0100 || jerry_keys !== 4'h0) begin
            errors++;
            $display("FAIL typematic_events got_n=%0d got=%p want=c,4", got.size(), got);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] seq [5] = '{16'h001C, 16'hF01C, 16'h001C, 16'hF01C, 16'h001C};
        do_reset();
        foreach (seq[i]) begin
            step(seq[i], 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL overflow_fill step=%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (ev_overflow !== 1'b1 || tom_keys[1] !== 1'b1) begin
            errors++;
            $display("FAIL overflow_flag got=%b lvl=%b want=1 1", ev_overflow, tom_keys[1]);
        end
        for (int i = 0; i < 5; i++) step(16'h001C, 1'b1);
        checks++;
        if (got.size() != 4 || got[0] !== 4'h9 || got[1] !== 4'h1 || got[2] !== 4'h9
            || got[3] !== 4'h1 || ev_valid !== 1'b0 || ev_overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_drain got=%p valid=%b want=9,1,9,1 valid=0", got, ev_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] seq [6] = '{16'h001C, 16'hF01C, 16'h001C, 16'hF01C, 16'h001C, 16'hF01C};
        do_reset();
        foreach (seq[i]) begin
            step(seq[i], i >= 4);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL full_push_pop step=%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
        end
        for (int i = 0; i < 6; i++) step(16'hF01C, 1'b1);
        checks++;
        if (got.size() != 6 || ev_overflow !== 1'b0 || got[0] !== 4'h9 || got[1] !== 4'h1
            || got[2] !== 4'h9 || got[3] !== 4'h1 || got[4] !== 4'h9 || got[5] !== 4'h1) begin
            errors++;
            $display("FAIL full_push_pop_order got=%p ovf=%b want=9,1,9,1,9,1 ovf=0", got, ev_overflow);
        end
    endtask

    task automatic test_enter_hold();
        int first = -1;
        int highs = 0;
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            step(16'h005A, 1'b1);
            if (game_rst) begin
                highs++;
                if (first < 0) first = i;
            end
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL enter_hold step=%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (first != 9 || highs != 3) begin
            errors++;
            $display("FAIL enter_pulse_shape first=%0d highs=%0d want=9 3", first, highs);
        end
        highs = 0;
        step(16'hF05A, 1'b1);
        for (int i = 0; i < 14; i++) begin
            step(16'h005A, 1'b1);
            if (game_rst) highs++;
        end
        checks++;
        if (highs != 3) begin
            errors++;
            $display("FAIL enter_refire highs=%0d want=3", highs);
        end
    endtask

    task automatic test_enter_short_and_async();
        int highs = 0;
        do_reset();
        for (int i = 0; i < 5; i++) step(16'h005A, 1'b1);
        for (int i = 0; i < 12; i++) begin
            step(16'hF05A, 1'b1);
            if (game_rst) highs++;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL enter_short step=%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (highs != 0) begin
            errors++;
            $display("FAIL enter_short_pulse highs=%0d want=0", highs);
        end
        step(16'h001D, 1'b0);
        for (int i = 0; i < 10; i++) step(16'h005A, 1'b0);
        checks++;
        if (game_rst !== 1'b1 || tom_keys[0] !== 1'b1) begin
            errors++;
            $display("FAIL pre_async_state game_rst=%b tom=%b want=1 1", game_rst, tom_keys[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs_vec() !== 15'h0) begin
            errors++;
            $display("FAIL async_reset got=%h want=%h", obs_vec(), 15'h0);
        end
        m_reset();
        keycode = 16'h0000;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [7:0]  codes [11] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h75, 8'h6B, 8'h72, 8'h74, 8'h5A, 8'h29, 8'h00};
        logic [7:0]  pfx [3] = '{8'h00, 8'hE0, 8'hF0};
        logic [15:0] kc = 16'h0000;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(3) == 0) kc = {pfx[$urandom_range(2)], codes[$urandom_range(10)]};
            step(kc, 1'($urandom_range(1)));
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc=%0d kc=%h got=%h want=%h", i, kc, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_tom_make_break();
        test_typematic();
        test_overflow();
        test_back_to_back();
        test_enter_hold();
        test_enter_short_and_async();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
